// File: rtl/hss_rx_bit_aligner_20_if.sv
// rtl/hss_rx_bit_aligner_20_if.sv - raw-word input and realigned-word output bundle for the RX bit aligner
interface hss_rx_bit_aligner_20_if #(
  parameter int W = 20
);
  logic [W-1:0] DIN;
  logic         DIN_VLD;
  logic [W-1:0] DOUT;
  logic         DOUT_VLD;
  logic         SYNC_HIT;
  logic         LOCKED;
  logic [4:0]   BIT_OFS;

  // master: deserializer side plus downstream consumer; slave: the aligner
  modport master (
    output DIN, DIN_VLD,
    input  DOUT, DOUT_VLD, SYNC_HIT, LOCKED, BIT_OFS
  );

  modport slave (
    input  DIN, DIN_VLD,
    output DOUT, DOUT_VLD, SYNC_HIT, LOCKED, BIT_OFS
  );
endinterface

// File: rtl/hss_rx_bit_aligner_20.sv
// rtl/hss_rx_bit_aligner_20.sv - hunt/verify/lock bit aligner that undoes a static 0..19 bit rotation
module hss_rx_bit_aligner_20 #(
  parameter int          W           = 20,
  parameter logic [19:0] SYNC_WORD   = 20'hA5F0C,
  parameter int          SYNC_PERIOD = 16,
  parameter int          LOCK_CNT    = 3,
  parameter int          UNLOCK_CNT  = 4
) (
  input logic                      TXDCLK,
  input logic                      Rst,
  hss_rx_bit_aligner_20_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [15:0] PHASE_LAST = 16'(SYNC_PERIOD - 1);
  localparam logic [7:0]  LOCK_N     = 8'(LOCK_CNT);
  localparam logic [7:0]  UNLOCK_N   = 8'(UNLOCK_CNT);

  state_t         state_q, state_d;
  logic [W-1:0]   prev_q, prev_d;
  logic [15:0]    phase_q, phase_d;
  logic [7:0]     hit_cnt_q, hit_cnt_d;
  logic [7:0]     miss_cnt_q, miss_cnt_d;
  logic [4:0]     bit_ofs_q, bit_ofs_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           dout_vld_q, dout_vld_d;
  logic           sync_hit_q, sync_hit_d;

  logic [2*W-1:0] window;
  logic           hunt_hit;
  logic [4:0]     hunt_k;
  logic [W-1:0]   cur_cand;
  logic           chk_now;
  logic           chk_match;
  logic [15:0]    phase_next;
  logic [7:0]     hit_inc;
  logic [7:0]     miss_inc;

  // cand(k) = {DIN[k-1:0], prev[W-1:k]}; k = 0 selects prev unchanged
  function automatic logic [W-1:0] cand(input logic [2*W-1:0] win, input logic [4:0] k);
    logic [2*W-1:0] sh;
    sh = win >> k;
    return sh[W-1:0];
  endfunction

  assign window     = {bus.DIN, prev_q};
  assign cur_cand   = cand(window, bit_ofs_q);
  assign chk_now    = (phase_q == 16'd0);
  assign chk_match  = (cur_cand == SYNC_WORD);
  assign phase_next = (phase_q == PHASE_LAST) ? 16'd0 : phase_q + 16'd1;
  assign hit_inc    = (hit_cnt_q == 8'hFF) ? hit_cnt_q : hit_cnt_q + 8'd1;
  assign miss_inc   = (miss_cnt_q == 8'hFF) ? miss_cnt_q : miss_cnt_q + 8'd1;

  // Descending scan so the lowest matching offset is the one left standing
  always_comb begin
    hunt_hit = 1'b0;
    hunt_k   = 5'd0;
    for (int k = W - 1; k >= 0; k--) begin
      if (cand(window, 5'(k)) == SYNC_WORD) begin
        hunt_hit = 1'b1;
        hunt_k   = 5'(k);
      end
    end
  end

  always_ff @(posedge TXDCLK) begin
    if (Rst) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    phase_d    = phase_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    bit_ofs_d  = bit_ofs_q;
    if (bus.DIN_VLD) begin
      prev_d = bus.DIN;
      case (state_q)
        ST_HUNT: begin
          if (hunt_hit) begin
            bit_ofs_d  = hunt_k;
            hit_cnt_d  = 8'd1;
            miss_cnt_d = 8'd0;
            phase_d    = 16'd1;
            state_d    = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          phase_d = phase_next;
          if (chk_now) begin
            if (chk_match) begin
              hit_cnt_d = hit_inc;
              if (hit_inc == LOCK_N) begin
                state_d    = ST_LOCKED;
                miss_cnt_d = 8'd0;
              end
            end else begin
              // The failing word is not rescanned; the hunt restarts on the next one
              state_d   = ST_HUNT;
              hit_cnt_d = 8'd0;
            end
          end
        end
        ST_LOCKED: begin
          phase_d = phase_next;
          if (chk_now) begin
            if (chk_match) begin
              miss_cnt_d = 8'd0;
            end else begin
              miss_cnt_d = miss_inc;
              if (miss_inc == UNLOCK_N) begin
                state_d = ST_HUNT;
              end
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    sync_hit_d = 1'b0;
    if (bus.DIN_VLD) begin
      dout_d     = cur_cand;
      dout_vld_d = (state_q == ST_LOCKED);
      sync_hit_d = (state_q == ST_LOCKED) && chk_now && chk_match;
    end
  end

  always_ff @(posedge TXDCLK) begin
    if (Rst) begin
      prev_q     <= '0;
      phase_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      bit_ofs_q  <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      sync_hit_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      phase_q    <= phase_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      bit_ofs_q  <= bit_ofs_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      sync_hit_q <= sync_hit_d;
    end
  end

  assign bus.DOUT     = dout_q;
  assign bus.DOUT_VLD = dout_vld_q;
  assign bus.SYNC_HIT = sync_hit_q;
  assign bus.LOCKED   = (state_q == ST_LOCKED);
  assign bus.BIT_OFS  = bit_ofs_q;

endmodule
